aes_shift_rows_stream: RTL
==========================

Name: aes_shift_rows_stream

Overview:
Streaming, parametrised ShiftRows/InvShiftRows engine for the AES/Rijndael datapath. It accepts one state block per handshake and applies the forward or inverse row rotation, selected per block. It supports Rijndael block widths Nb = 4/6/8 columns. Results are buffered in an internal FIFO with valid/ready flow control, so the block can sit between SubBytes and MixColumns stages that stall independently.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; data width is NB*32.
DEPTH, 2, output FIFO entries; power of two, at least 2.
TAG_W, 4, width of the sideband tag carried alongside each block.

Ports:
clk  input  1  clock
reset_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of all buffered blocks
in_valid  input  1  input block present
in_ready  output  1  block can accept input
in_data  input  NB*32  state, column-major; byte k at bits [NB*32-1-8k -: 8]; byte k = row k%4, column k/4
in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows
in_tag  input  TAG_W  opaque sideband
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_data  output  NB*32  transformed state
out_tag  output  TAG_W  tag of the head entry
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Row offsets:
  - NB=4 or NB=6: rows 0..3 shift by 0, 1, 2, 3.
  - NB=8: rows 0..3 shift by 0, 1, 3, 4.
- Forward transform: out[r][c] = in[r][(c+off[r]) mod NB].
- Inverse transform: out[r][c] = in[r][(c-off[r]+NB) mod NB].
- The permutation is combinational on in_data. The result is written into the FIFO on accept.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (level != DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (level != 0).
- out_data and out_tag are driven from the head entry. They are forced to 0 when level == 0.
- Latency: a block accepted at edge k is presented with out_valid=1 in the cycle after edge k. Throughput is 1 block/cycle while the consumer is ready.
- Simultaneous push and pop: level is unchanged and the pointers advance. A push is never possible when full. A pop is never possible when empty.
- Pointers wrap modulo DEPTH.
- Order is preserved, including mixed in_inv blocks.
- flush takes priority over push and pop at the same edge: level, read pointer and write pointer go to 0. A push presented in a flush cycle is dropped.
- Reset (asynchronous, may occur mid-stream): level=0, pointers=0, out_valid=0, in_ready=1 after release, out_data=0, out_tag=0. FIFO storage itself is not reset.
- Illegal NB or DEPTH: elaboration-time error.

Optional Feature:
Macro AES_SR_PARITY_EN.
- Defined:
  - Extra input in_par [NB*4-1:0], one even-parity bit per input byte.
  - The parity vector is permuted identically to the bytes, stored, and output as out_par [NB*4-1:0].
  - Output par_err: a 1-bit pulse, registered one cycle after an accepted block whose byte parity mismatches in_par.
  - Reset value of out_par and par_err is 0.
- Undefined: in_par, out_par and par_err are absent, with no extra storage.

Decomposition:
- Package aes_pkg:
  - Byte width constant (8).
  - Row count constant (4).
  - Function shift_offset(nb, row).
  - Function byte_index(row, col).
  - Legal-NB check.
- Sub-module aes_sr_fifo: a generic DEPTH x width synchronous FIFO with flush and level output. It is reused for the data+tag(+parity) word.
- The permutation stays as a generate loop in the top module.

Test Plan:
- NB=4, in_inv=0, in_data=128'hd42711aee0bf98f1b8b45de51e415230 (FIPS-197 round-1 SubBytes output) -> one cycle later out_valid=1, out_data=128'hd4bf5d30e0b452aeb84111f11e2798e5.
- NB=4, in_inv=1, in_data=128'hd4bf5d30e0b452aeb84111f11e2798e5 -> out_data=128'hd42711aee0bf98f1b8b45de51e415230. Also: bytes 00..0f forward -> 00050a0f04090e03080d02070c01060b.
- NB=8, in_inv=0, bytes 00..1f -> column 0 of out_data = 00 05 0e 13 (row-3 offset 4). Forward then inverse round-trip returns the input.
- DEPTH=2, out_ready=0, push 3 blocks with tags 1, 2, 3 -> in_ready=0 after 2 pushes, level=2, block 3 held. Raising out_ready gives tags 1, 2, 3 in order, with no duplicate or loss.
- flush asserted with level=2 and a push in the same cycle -> next cycle level=0, out_valid=0, out_data=0. reset_n pulsed low mid-stream -> all outputs at reset values immediately.
- AES_SR_PARITY_EN defined, one in_par bit flipped -> par_err=1 for exactly one cycle. out_par is the permuted vector.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared constants and index helpers for the ShiftRows stream engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int c_BYTE_W = 8;
    localparam int c_ROWS   = 4;

    // Rijndael Nb=8 uses offsets 0,1,3,4; Nb=4/6 use 0,1,2,3.
    function automatic int shift_offset(input int nb, input int row);
        if (nb == 8 && row >= 2) return row + 1;
        return row;
    endfunction

    function automatic int byte_index(input int row, input int col);
        return col * c_ROWS + row;
    endfunction

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_shift_rows_stream_if.sv
// ============================================================================
// Module  : aes_shift_rows_stream_if
// Brief   : Input/output stream bundle of the ShiftRows engine.
//           Parity lanes exist only when AES_SR_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_shift_rows_stream_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [NB*32-1:0]         in_data;
    logic                     in_inv;
    logic [TAG_W-1:0]         in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [NB*32-1:0]         out_data;
    logic [TAG_W-1:0]         out_tag;
    logic [$clog2(DEPTH):0]   level;
`ifdef AES_SR_PARITY_EN
    logic [NB*4-1:0]          in_par;
    logic [NB*4-1:0]          out_par;
    logic                     par_err;
`endif

    modport slave (
        input  flush, in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, level
`ifdef AES_SR_PARITY_EN
        , input in_par, output out_par, par_err
`endif
    );

    modport master (
        output flush, in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, level
`ifdef AES_SR_PARITY_EN
        , output in_par, input out_par, par_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/aes_sr_fifo.sv
// ============================================================================
// Module  : aes_sr_fifo
// Brief   : DEPTH x WIDTH synchronous FIFO with flush and occupancy output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     i_flush,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_P_ONE = 1;
    localparam logic [c_AW:0]     c_L_ONE = 1;
    localparam logic [c_AW:0]     c_FULL  = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == c_FULL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_P_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_P_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_L_ONE;
                2'b01:   r_level <= r_level - c_L_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/aes_shift_rows_stream.sv
// ============================================================================
// Module  : aes_shift_rows_stream
// Brief   : Streaming ShiftRows/InvShiftRows for Nb=4/6/8 with output FIFO.
//           Optional byte-parity lanes: define AES_SR_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    aes_shift_rows_stream_if.slave bus
);

    localparam int c_DW = NB * 32;
    localparam int c_NBYTES = NB * c_ROWS;
`ifdef AES_SR_PARITY_EN
    localparam int c_WW = c_DW + TAG_W + c_NBYTES;
`else
    localparam int c_WW = c_DW + TAG_W;
`endif

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aes_shift_rows_stream: DEPTH must be a power of two >= 2");
    end

    logic [c_DW-1:0] w_fwd;
    logic [c_DW-1:0] w_inv;
    logic [c_DW-1:0] w_perm;
    logic [c_WW-1:0] w_wr_word;
    logic [c_WW-1:0] w_rd_word;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

`ifdef AES_SR_PARITY_EN
    logic [c_NBYTES-1:0] w_par_fwd;
    logic [c_NBYTES-1:0] w_par_inv;
    logic [c_NBYTES-1:0] w_calc_par;
    logic                r_par_err;
`endif

    // Byte k lives at the MSB end: bits [c_DW-1-8k -: 8]; parity bit k at [c_NBYTES-1-k].
    for (genvar r = 0; r < c_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int c_OFF  = shift_offset(NB, r);
            localparam int c_DST  = byte_index(r, c);
            localparam int c_FSRC = byte_index(r, (c + c_OFF) % NB);
            localparam int c_ISRC = byte_index(r, (c - c_OFF + NB) % NB);

            assign w_fwd[c_DW-1-c_BYTE_W*c_DST -: c_BYTE_W] =
                bus.in_data[c_DW-1-c_BYTE_W*c_FSRC -: c_BYTE_W];
            assign w_inv[c_DW-1-c_BYTE_W*c_DST -: c_BYTE_W] =
                bus.in_data[c_DW-1-c_BYTE_W*c_ISRC -: c_BYTE_W];
`ifdef AES_SR_PARITY_EN
            assign w_par_fwd[c_NBYTES-1-c_DST]  = bus.in_par[c_NBYTES-1-c_FSRC];
            assign w_par_inv[c_NBYTES-1-c_DST]  = bus.in_par[c_NBYTES-1-c_ISRC];
            assign w_calc_par[c_NBYTES-1-c_DST] = ^bus.in_data[c_DW-1-c_BYTE_W*c_DST -: c_BYTE_W];
`endif
        end
    end

    assign w_perm = bus.in_inv ? w_inv : w_fwd;
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

`ifdef AES_SR_PARITY_EN
    assign w_wr_word = {w_perm, bus.in_tag, (bus.in_inv ? w_par_inv : w_par_fwd)};
`else
    assign w_wr_word = {w_perm, bus.in_tag};
`endif

    aes_sr_fifo #(
        .WIDTH (c_WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (bus.flush),
        .i_push    (w_push),
        .i_wr_data (w_wr_word),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_word),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (bus.level)
    );

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_rd_word[c_WW-1 -: c_DW];
    assign bus.out_tag   = w_rd_word[c_WW-1-c_DW -: TAG_W];

`ifdef AES_SR_PARITY_EN
    assign bus.out_par = w_rd_word[c_NBYTES-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_par_err <= 1'b0;
        else          r_par_err <= w_push && (w_calc_par != bus.in_par);
    end

    assign bus.par_err = r_par_err;
`endif

endmodule

`default_nettype wire
